// File: rtl/sram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sram_ctrl_pkg : shared constants, FSM encoding and geometry helpers
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sram_ctrl_pkg;

  localparam int MACRO_DEPTH  = 256;
  localparam int MACRO_W      = 8;
  localparam int MACRO_ADDR_W = 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  function automatic int calc_rows(input int depth);
    return depth / MACRO_DEPTH;
  endfunction

  function automatic int calc_cols(input int data_w);
    return data_w / MACRO_W;
  endfunction

  function automatic int calc_addr_w(input int depth);
    return (depth <= MACRO_DEPTH) ? MACRO_ADDR_W : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gf180mcu_fd_ip_sram__sram256x8m8wm1.sv
// ----------------------------------------------------------------------------
// gf180mcu_fd_ip_sram__sram256x8m8wm1 : behavioural 256x8 macro, bit write mask
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gf180mcu_fd_ip_sram__sram256x8m8wm1 (
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [7:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q,
  inout  wire        VDD,
  inout  wire        VSS
);

  logic [7:0] mem_q [256];
  logic       pwr_ok;

  assign pwr_ok = VDD & ~VSS;

  // Q only updates on a read; writes leave the last read value on the pins.
  always_ff @(posedge CLK) begin
    if (!CEN && pwr_ok) begin
      if (!GWEN) begin
        for (int b = 0; b < 8; b++) begin
          if (!WEN[b]) mem_q[A][b] <= D[b];
        end
      end else begin
        Q <= mem_q[A];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_array_ctrl_row.sv
// ----------------------------------------------------------------------------
// sram_row : one row of COLS byte-wide macros with shared CEN/GWEN/A
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_row
  import sram_ctrl_pkg::*;
#(
  parameter int COLS = 4
) (
  input  logic                    CLK,
  input  logic                    CEN,
  input  logic                    GWEN,
  input  logic [COLS*MACRO_W-1:0] WEN,
  input  logic [MACRO_ADDR_W-1:0] A,
  input  logic [COLS*MACRO_W-1:0] D,
  output logic [COLS*MACRO_W-1:0] Q,
  inout  wire                     VDD,
  inout  wire                     VSS
);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    gf180mcu_fd_ip_sram__sram256x8m8wm1 u_macro (
      .CLK  (CLK),
      .CEN  (CEN),
      .GWEN (GWEN),
      .WEN  (WEN[c*MACRO_W +: MACRO_W]),
      .A    (A),
      .D    (D[c*MACRO_W +: MACRO_W]),
      .Q    (Q[c*MACRO_W +: MACRO_W]),
      .VDD  (VDD),
      .VSS  (VSS)
    );
  end

endmodule

`default_nettype wire

// File: rtl/sram_array_ctrl.sv
// ----------------------------------------------------------------------------
// sram_array_ctrl : tiles 256x8 macros into DATA_W x DEPTH with zero-fill sweep
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_array_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 512,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [calc_addr_w(DEPTH)-1:0] req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [DATA_W/8-1:0]           req_be,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  input  logic                          clear_req,
  output logic                          busy,
  inout  wire                           VDD,
  inout  wire                           VSS
);

  localparam int COLS   = calc_cols(DATA_W);
  localparam int ROWS   = calc_rows(DEPTH);
  localparam int ADDR_W = calc_addr_w(DEPTH);
  localparam int ROW_W  = (ADDR_W > MACRO_ADDR_W) ? ADDR_W - MACRO_ADDR_W : 1;

  state_e                  state_q, state_d;
  logic [MACRO_ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic                    clr_pend_q, clr_pend_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [ROW_W-1:0]        rd_row_q, rd_row_d;

  logic [ROW_W-1:0]        req_row;
  logic                    req_oor;
  logic                    req_accept;
  logic [ROWS-1:0]         mem_cen;
  logic                    mem_gwen;
  logic [DATA_W-1:0]       mem_wen;
  logic [DATA_W-1:0]       mem_d;
  logic [MACRO_ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0]       row_q [ROWS];

  if (ADDR_W > MACRO_ADDR_W) begin : g_row_field
    assign req_row = req_addr[ADDR_W-1:MACRO_ADDR_W];
  end else begin : g_row_single
    assign req_row = '0;
  end

  assign req_oor    = 32'(req_addr) >= 32'(DEPTH);
  assign req_ready  = RSTN && (state_q == ST_IDLE) && !(rsp_valid_q && !rsp_ready);
  assign req_accept = req_valid && req_ready;
  assign busy       = (state_q == ST_CLEAR);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_pend_d  = clr_pend_q || clear_req;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_err_d   = rsp_err_q && rsp_valid_d;
    rd_row_d    = rd_row_q;
    mem_cen     = '1;
    mem_gwen    = 1'b1;
    mem_wen     = '1;
    mem_d       = '0;
    mem_a       = req_addr[MACRO_ADDR_W-1:0];
    case (state_q)
      ST_CLEAR: begin
        mem_cen    = '0;
        mem_gwen   = 1'b0;
        mem_wen    = '0;
        mem_a      = clr_addr_q;
        clr_pend_d = 1'b0;
        clr_addr_d = clr_addr_q + 8'd1;
        if (clr_addr_q == '1) state_d = ST_IDLE;
      end
      default: begin
        if (req_accept) begin
          mem_gwen = ~req_we;
          mem_d    = req_wdata;
          for (int c = 0; c < COLS; c++) begin
            mem_wen[c*MACRO_W +: MACRO_W] = {MACRO_W{~req_be[c]}};
          end
          // Out-of-range or all-masked writes touch no macro at all.
          if (!req_oor && (!req_we || (|req_be))) begin
            for (int r = 0; r < ROWS; r++) begin
              if (req_row == ROW_W'(r)) mem_cen[r] = 1'b0;
            end
          end
          if (!req_we) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_oor;
            rd_row_d    = req_row;
          end
        end
        // A pending response must be consumed before the sweep may start.
        if ((clear_req || clr_pend_q) && (!rsp_valid_q || rsp_ready)) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          clr_pend_d = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    rsp_rdata = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rsp_valid_q && !rsp_err_q && (rd_row_q == ROW_W'(r))) rsp_rdata = row_q[r];
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_addr_q  <= '0;
      clr_pend_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_row_q    <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_pend_q  <= clr_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_row_q    <= rd_row_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    sram_row #(
      .COLS (COLS)
    ) u_row (
      .CLK  (CLK),
      .CEN  (mem_cen[r]),
      .GWEN (mem_gwen),
      .WEN  (mem_wen),
      .A    (mem_a),
      .D    (mem_d),
      .Q    (row_q[r]),
      .VDD  (VDD),
      .VSS  (VSS)
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_array_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram_array_ctrl : directed bench for 32x512 and 32x768 array controllers
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sram_array_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  wire  vdd;
  wire  vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic        a_clear_req, a_busy;
  logic [8:0]  a_req_addr;
  logic [31:0] a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic        b_clear_req, b_busy;
  logic [9:0]  b_req_addr;
  logic [31:0] b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  always #5 clk = ~clk;

  sram_array_ctrl #(.DATA_W(32), .DEPTH(512), .CLEAR_ON_RESET(1'b1)) dut_a (
    .CLK(clk), .RSTN(rstn),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .clear_req(a_clear_req), .busy(a_busy),
    .VDD(vdd), .VSS(vss)
  );

  sram_array_ctrl #(.DATA_W(32), .DEPTH(768), .CLEAR_ON_RESET(1'b1)) dut_b (
    .CLK(clk), .RSTN(rstn),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .clear_req(b_clear_req), .busy(b_busy),
    .VDD(vdd), .VSS(vss)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit b, input bit we, input logic [9:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input string tag);
    if (!b) begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr[8:0];
      a_req_wdata = wd;   a_req_be = be;
    end else begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr;
      b_req_wdata = wd;   b_req_be = be;
    end
    #1;
    chk({tag, " ready"}, b ? b_req_ready : a_req_ready, 1);
    step();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic chk_rsp(input bit b, input string tag, input logic [31:0] data, input bit err);
    chk({tag, " valid"}, b ? b_rsp_valid : a_rsp_valid, 1);
    chk({tag, " data"},  b ? b_rsp_rdata : a_rsp_rdata, data);
    chk({tag, " err"},   b ? b_rsp_err   : a_rsp_err,   err);
  endtask

  initial begin
    a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
    a_rsp_ready = 1; a_clear_req = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    b_rsp_ready = 1; b_clear_req = 0;

    // Reset state
    #12;
    chk("rst busy", a_busy, 1);
    chk("rst req_ready", a_req_ready, 0);
    chk("rst rsp_valid", a_rsp_valid, 0);
    chk("rst rsp_rdata", a_rsp_rdata, 0);
    chk("rst rsp_err", a_rsp_err, 0);
    chk("rst b busy", b_busy, 1);

    // Post-reset sweep: 256 busy cycles
    @(negedge clk);
    rstn = 1'b1;
    repeat (255) step();
    chk("sweep255 busy", a_busy, 1);
    chk("sweep255 ready", a_req_ready, 0);
    step();
    chk("sweep done busy", a_busy, 0);
    chk("sweep done ready", a_req_ready, 1);
    chk("sweep done b busy", b_busy, 0);

    // Cleared location reads zero, one cycle after acceptance
    req(0, 0, 10'h1FF, 32'h0, 4'h0, "rd 1ff");
    chk_rsp(0, "rd 1ff", 32'h0000_0000, 0);
    step();
    chk("rd 1ff drop valid", a_rsp_valid, 0);
    chk("rd 1ff drop data", a_rsp_rdata, 0);

    // Byte-masked merge, and an all-masked write that must change nothing
    req(0, 1, 10'h0AB, 32'hDEAD_BEEF, 4'b1111, "wr ab full");
    req(0, 1, 10'h0AB, 32'h1122_3344, 4'b0101, "wr ab mask");
    req(0, 1, 10'h0AB, 32'h0000_0000, 4'b0000, "wr ab be0");
    req(0, 0, 10'h0AB, 32'h0, 4'h0, "rd ab");
    chk_rsp(0, "rd ab", 32'hDE22_BE44, 0);

    // Two rows, back-to-back reads
    req(0, 1, 10'h000, 32'hA5A5_A5A5, 4'hF, "wr 000");
    req(0, 1, 10'h100, 32'h5A5A_5A5A, 4'hF, "wr 100");
    a_req_valid = 1; a_req_we = 0; a_req_addr = 9'h000;
    step();
    a_req_addr = 9'h100;
    #1;
    chk_rsp(0, "b2b first", 32'hA5A5_A5A5, 0);
    chk("b2b ready", a_req_ready, 1);
    step();
    a_req_valid = 0;
    chk_rsp(0, "b2b second", 32'h5A5A_5A5A, 0);
    step();
    chk("b2b idle", a_rsp_valid, 0);

    // Backpressure: response holds, no new request accepted
    a_rsp_ready = 0;
    req(0, 0, 10'h0AB, 32'h0, 4'h0, "stall rd");
    a_req_valid = 1; a_req_we = 0; a_req_addr = 9'h100;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall valid", a_rsp_valid, 1);
      chk("stall data", a_rsp_rdata, 32'hDE22_BE44);
      chk("stall ready", a_req_ready, 0);
      step();
    end
    a_rsp_ready = 1;
    #1;
    chk("release ready", a_req_ready, 1);
    step();
    a_req_valid = 0;
    chk_rsp(0, "release next", 32'h5A5A_5A5A, 0);
    step();
    chk("release idle", a_rsp_valid, 0);

    // DEPTH=768: out-of-range write dropped, read flagged
    req(1, 1, 10'h300, 32'hFFFF_FFFF, 4'hF, "b wr 300");
    req(1, 1, 10'h2FF, 32'h1234_5678, 4'hF, "b wr 2ff");
    req(1, 0, 10'h000, 32'h0, 4'h0, "b rd 000");
    chk_rsp(1, "b rd 000", 32'h0, 0);
    req(1, 0, 10'h300, 32'h0, 4'h0, "b rd 300");
    chk_rsp(1, "b rd 300", 32'h0, 1);
    req(1, 0, 10'h2FF, 32'h0, 4'h0, "b rd 2ff");
    chk_rsp(1, "b rd 2ff", 32'h1234_5678, 0);
    step();
    chk("b idle", b_rsp_valid, 0);

    // clear_req pulse while a response is stalled
    a_rsp_ready = 0;
    req(0, 0, 10'h000, 32'h0, 4'h0, "clr rd");
    a_clear_req = 1;
    step();
    a_clear_req = 0;
    chk("clr wait busy", a_busy, 0);
    chk("clr wait valid", a_rsp_valid, 1);
    step();
    chk("clr wait2 busy", a_busy, 0);
    a_rsp_ready = 1;
    #1;
    chk_rsp(0, "clr pending", 32'hA5A5_A5A5, 0);
    step();
    chk("clr start busy", a_busy, 1);
    chk("clr start valid", a_rsp_valid, 0);
    chk("clr start ready", a_req_ready, 0);
    repeat (255) step();
    chk("clr 256 busy", a_busy, 1);
    step();
    chk("clr end busy", a_busy, 0);
    req(0, 0, 10'h000, 32'h0, 4'h0, "clr rd 000");
    chk_rsp(0, "clr rd 000", 32'h0, 0);
    req(0, 0, 10'h0AB, 32'h0, 4'h0, "clr rd ab");
    chk_rsp(0, "clr rd ab", 32'h0, 0);
    req(0, 0, 10'h100, 32'h0, 4'h0, "clr rd 100");
    chk_rsp(0, "clr rd 100", 32'h0, 0);
    step();

    // Reset mid-sweep restarts it; pending response on the other array is discarded
    b_rsp_ready = 0;
    req(1, 0, 10'h2FF, 32'h0, 4'h0, "b pend");
    chk_rsp(1, "b pend", 32'h1234_5678, 0);
    a_clear_req = 1;
    step();
    a_clear_req = 0;
    chk("mid busy", a_busy, 1);
    repeat (100) step();
    chk("mid100 busy", a_busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid rst busy", a_busy, 1);
    chk("mid rst ready", a_req_ready, 0);
    chk("mid rst b valid", b_rsp_valid, 0);
    chk("mid rst b data", b_rsp_rdata, 0);
    step();
    step();
    chk("in rst busy", a_busy, 1);
    @(negedge clk);
    rstn = 1'b1;
    b_rsp_ready = 1;
    repeat (255) step();
    chk("restart 255 busy", a_busy, 1);
    step();
    chk("restart done busy", a_busy, 0);
    chk("restart done ready", a_req_ready, 1);
    chk("restart b valid", b_rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
